// File: rtl/gpu_cmd_controller.sv
// gpu_cmd_controller
// Avalon-MM slave front end for the triangle command path. Software programs
// three vertex words and a colour word, then writes an opcode to CMD. Each
// non-zero opcode snapshots the register file into a small command FIFO, and
// a three-state sequencer hands the queued commands to the rasterizer one at
// a time: present on cmd_valid, wait for cmd_ready, then wait for cmd_done.

module gpu_cmd_controller #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              avs_chipselect,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_opcode,
  output logic [DATA_W-1:0] cmd_v0,
  output logic [DATA_W-1:0] cmd_v1,
  output logic [DATA_W-1:0] cmd_v2,
  output logic [DATA_W-1:0] cmd_colour,
  input  logic              cmd_done
);

  // The count needs one bit more than the pointers so "full" is distinct
  // from "empty" when the pointers are equal.
  localparam int               CNT_W    = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  localparam logic [2:0] ADDR_VTX0   = 3'd0;
  localparam logic [2:0] ADDR_VTX1   = 3'd1;
  localparam logic [2:0] ADDR_VTX2   = 3'd2;
  localparam logic [2:0] ADDR_COLOUR = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_CMD    = 3'd5;

  // One queued command: opcode plus the register snapshot taken at CMD write.
  typedef struct packed {
    logic [7:0]        opcode;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] colour;
  } cmd_t;

  localparam cmd_t CMD_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // Register file and read path state
  logic [DATA_W-1:0] vtx0_q, vtx0_d;
  logic [DATA_W-1:0] vtx1_q, vtx1_d;
  logic [DATA_W-1:0] vtx2_q, vtx2_d;
  logic [DATA_W-1:0] colour_q, colour_d;
  logic [7:0]        last_opcode_q, last_opcode_d;
  logic              err_q, err_d;
  logic [7:0]        done_count_q, done_count_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              readdatavalid_q, readdatavalid_d;

  // Command FIFO state
  cmd_t              fifo_mem_q [FIFO_DEPTH];
  cmd_t              fifo_mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Sequencer state and rasterizer-facing output registers
  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;

  // Decoded strobes
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              wait_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              push_s;
  logic              pop_s;
  logic              done_inc_s;
  logic              done_clr_s;
  logic              busy_s;
  cmd_t              push_entry_s;
  cmd_t              head_s;
  logic [DATA_W-1:0] status_s;

  assign fifo_full_s  = (count_q == FULL_CNT);
  assign fifo_empty_s = (count_q == ZERO_CNT);

  // Only a CMD write into a full FIFO stalls; a pop in the same cycle does
  // not release it, which keeps waitrequest free of any path from cmd_ready.
  assign wait_s   = avs_chipselect & avs_write & (avs_address == ADDR_CMD) & fifo_full_s;
  assign wr_acc_s = avs_chipselect & avs_write & ~wait_s;
  // A simultaneous read and write is handled as the write alone.
  assign rd_acc_s = avs_chipselect & avs_read & ~avs_write & ~wait_s;

  assign push_s       = wr_acc_s & (avs_address == ADDR_CMD) & (avs_writedata[7:0] != 8'd0);
  assign push_entry_s = {avs_writedata[7:0], vtx0_q, vtx1_q, vtx2_q, colour_q};
  assign head_s       = fifo_mem_q[rd_ptr_q];
  assign done_clr_s   = wr_acc_s & (avs_address == ADDR_STATUS) & avs_writedata[9];
  assign busy_s       = ~fifo_empty_s | (state_q != ST_IDLE);

  // Assemble the STATUS word from live FIFO, sequencer and sticky state.
  always_comb begin
    status_s       = {DATA_W{1'b0}};
    status_s[0]    = busy_s;
    status_s[1]    = fifo_full_s;
    status_s[2]    = fifo_empty_s;
    status_s[3]    = err_q;
    status_s[7:4]  = 4'(count_q);
    status_s[15:8] = done_count_q;
  end

  // Register writes, error flag and the registered read-data path.
  always_comb begin
    vtx0_d          = vtx0_q;
    vtx1_d          = vtx1_q;
    vtx2_d          = vtx2_q;
    colour_d        = colour_q;
    last_opcode_d   = last_opcode_q;
    err_d           = err_q;
    readdata_d      = readdata_q;
    readdatavalid_d = 1'b0;
    if (wr_acc_s) begin
      case (avs_address)
        ADDR_VTX0:   vtx0_d   = avs_writedata;
        ADDR_VTX1:   vtx1_d   = avs_writedata;
        ADDR_VTX2:   vtx2_d   = avs_writedata;
        ADDR_COLOUR: colour_d = avs_writedata;
        ADDR_STATUS: begin
          if (avs_writedata[3]) begin
            err_d = 1'b0;
          end else begin
            err_d = err_q;
          end
        end
        ADDR_CMD:    last_opcode_d = avs_writedata[7:0];
        default:     err_d = 1'b1;
      endcase
    end else if (rd_acc_s) begin
      readdatavalid_d = 1'b1;
      case (avs_address)
        ADDR_VTX0:   readdata_d = vtx0_q;
        ADDR_VTX1:   readdata_d = vtx1_q;
        ADDR_VTX2:   readdata_d = vtx2_q;
        ADDR_COLOUR: readdata_d = colour_q;
        ADDR_STATUS: readdata_d = status_s;
        ADDR_CMD:    readdata_d = {{(DATA_W-8){1'b0}}, last_opcode_q};
        default: begin
          readdata_d = {DATA_W{1'b0}};
          err_d      = 1'b1;
        end
      endcase
    end else begin
      readdatavalid_d = 1'b0;
    end
  end

  // Command FIFO: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = push_entry_s;
      wr_ptr_d             = wr_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Sequencer: pop into the output registers, hold until ready, wait for done.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    pop_s       = 1'b0;
    done_inc_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          cmd_d       = head_s;
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          cmd_valid_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        // A done pulse coinciding with the handshake belongs to nothing yet.
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_WAIT_DONE;
        end else begin
          cmd_valid_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (cmd_done) begin
          done_inc_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        cmd_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Completed-command counter; a software clear beats a same-cycle increment.
  always_comb begin
    done_count_d = done_count_q;
    if (done_clr_s) begin
      done_count_d = 8'd0;
    end else if (done_inc_s) begin
      done_count_d = done_count_q + 8'd1;
    end else begin
      done_count_d = done_count_q;
    end
  end

  // Control, register file and output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vtx0_q          <= {DATA_W{1'b0}};
      vtx1_q          <= {DATA_W{1'b0}};
      vtx2_q          <= {DATA_W{1'b0}};
      colour_q        <= {DATA_W{1'b0}};
      last_opcode_q   <= 8'd0;
      err_q           <= 1'b0;
      done_count_q    <= 8'd0;
      readdata_q      <= {DATA_W{1'b0}};
      readdatavalid_q <= 1'b0;
      wr_ptr_q        <= {FIFO_AW{1'b0}};
      rd_ptr_q        <= {FIFO_AW{1'b0}};
      count_q         <= ZERO_CNT;
      state_q         <= ST_IDLE;
      cmd_q           <= CMD_ZERO;
      cmd_valid_q     <= 1'b0;
    end else begin
      vtx0_q          <= vtx0_d;
      vtx1_q          <= vtx1_d;
      vtx2_q          <= vtx2_d;
      colour_q        <= colour_d;
      last_opcode_q   <= last_opcode_d;
      err_q           <= err_d;
      done_count_q    <= done_count_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      cmd_valid_q     <= cmd_valid_d;
    end
  end

  // FIFO storage, cleared on reset so stale snapshots never reappear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= CMD_ZERO;
      end
    end else begin
      fifo_mem_q <= fifo_mem_d;
    end
  end

  assign avs_waitrequest   = wait_s;
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
  assign cmd_valid         = cmd_valid_q;
  assign cmd_opcode        = cmd_q.opcode;
  assign cmd_v0            = cmd_q.v0;
  assign cmd_v1            = cmd_q.v1;
  assign cmd_v2            = cmd_q.v2;
  assign cmd_colour        = cmd_q.colour;

endmodule

// File: tb/tb_gpu_cmd_controller.sv
// tb_gpu_cmd_controller
// Randomised bench for gpu_cmd_controller. A behavioural model (register
// array, queue of pending command snapshots, err/done counters) predicts
// STATUS, read data and the order and contents of issued commands.

module tb_gpu_cmd_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        avs_chipselect;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_v0;
  logic [31:0] cmd_v1;
  logic [31:0] cmd_v2;
  logic [31:0] cmd_colour;
  logic        cmd_done;

  always #5 clk = ~clk;

  gpu_cmd_controller #(.DATA_W(32), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_chipselect(avs_chipselect), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_v0(cmd_v0), .cmd_v1(cmd_v1), .cmd_v2(cmd_v2), .cmd_colour(cmd_colour),
    .cmd_done(cmd_done)
  );

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0]  op;
    logic [31:0] v0, v1, v2, col;
  } cmd_s;

  logic [31:0] m_reg [4];
  logic [7:0]  m_last;
  bit          m_err;
  logic [7:0]  m_done;
  cmd_s        pending[$];
  cmd_s        cur;
  bit          m_issue;   // a command is on cmd_valid awaiting ready
  bit          m_wait;    // a command was accepted and awaits done

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
    m_last = 8'd0; m_err = 1'b0; m_done = 8'd0;
    pending.delete(); m_issue = 1'b0; m_wait = 1'b0;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    cmd_s c;
    if (a <= 3'd3) begin
      m_reg[a[1:0]] = d;
    end else if (a == 3'd4) begin
      if (d[3]) m_err = 1'b0;
      if (d[9]) m_done = 8'd0;
    end else if (a == 3'd5) begin
      m_last = d[7:0];
      if (d[7:0] != 8'd0) begin
        c.op = d[7:0]; c.v0 = m_reg[0]; c.v1 = m_reg[1]; c.v2 = m_reg[2]; c.col = m_reg[3];
        pending.push_back(c);
      end
    end else begin
      m_err = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = pending.size();
    s = 32'd0;
    s[0] = (n != 0) || m_issue || m_wait;
    s[1] = (n == 4);
    s[2] = (n == 0);
    s[3] = m_err;
    s[7:4] = 4'(n);
    s[15:8] = m_done;
    return s;
  endfunction

  // ---------------- bus and handshake drivers ----------------
  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    #1;
    while (avs_waitrequest === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 100) begin
      n_total++;
      $display("FAIL wr_timeout got=stalled exp=accepted addr=%0d", a);
    end
    @(posedge clk);
    model_write(a, d);
    #1;
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d,
                        output logic v1, output logic v2);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(posedge clk);
    if (a >= 3'd6) m_err = 1'b1;
    #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    @(negedge clk);
    v1 = avs_readdatavalid; d = avs_readdata;
    @(negedge clk);
    v2 = avs_readdatavalid;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (cmd_valid === 1'b1);
  endtask

  function automatic void consume();
    if (pending.size() > 0) cur = pending.pop_front();
    m_issue = 1'b1;
  endfunction

  task automatic do_ready();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(posedge clk);
    m_issue = 1'b0; m_wait = 1'b1;
    #1;
    cmd_ready = 1'b0;
  endtask

  task automatic do_done(input bit with_ready);
    @(negedge clk);
    cmd_done = 1'b1;
    cmd_ready = with_ready;
    @(posedge clk);
    if (with_ready) begin
      m_issue = 1'b0; m_wait = 1'b1;
    end else if (m_wait) begin
      m_done = m_done + 8'd1; m_wait = 1'b0;
    end
    #1;
    cmd_done = 1'b0; cmd_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    avs_chipselect = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic v1, v2;
    apply_reset();
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", cmd_valid); else n_pass++;
    n_total++; if ({avs_readdatavalid, avs_readdata} !== 33'd0) $display("FAIL rst_rdata got=%h exp=0", {avs_readdatavalid, avs_readdata}); else n_pass++;
    n_total++; if ({cmd_opcode, cmd_v0, cmd_v1, cmd_v2, cmd_colour} !== 136'd0) $display("FAIL rst_cmd got=%h exp=0", {cmd_opcode, cmd_v0}); else n_pass++;
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== 32'h0000_0004) $display("FAIL rst_status got=%h exp=00000004", d); else n_pass++;
  endtask

  task automatic test_readback();
    logic [31:0] d; logic v1, v2; int st;
    avs_wr(3'd0, 32'h0020_0010, st);
    avs_wr(3'd3, 32'h00FF_00FF, st);
    avs_rd(3'd0, d, v1, v2);
    n_total++; if (d !== 32'h0020_0010) $display("FAIL rb_vtx0 got=%h exp=00200010", d); else n_pass++;
    n_total++; if ({v1, v2} !== 2'b10) $display("FAIL rb_rdv got=%b exp=10", {v1, v2}); else n_pass++;
    avs_rd(3'd3, d, v1, v2);
    n_total++; if (d !== 32'h00FF_00FF) $display("FAIL rb_colour got=%h exp=00ff00ff", d); else n_pass++;
    n_total++; if ({v1, v2} !== 2'b10) $display("FAIL rb_rdv2 got=%b exp=10", {v1, v2}); else n_pass++;
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== 32'h0000_0004) $display("FAIL rb_status got=%h exp=00000004", d); else n_pass++;
  endtask

  task automatic test_single_cmd();
    logic [31:0] d; logic v1, v2; int st; bit stable;
    avs_wr(3'd1, 32'h0040_0030, st);
    avs_wr(3'd2, 32'h0010_0050, st);
    avs_wr(3'd5, 32'h0000_0001, st);
    @(negedge clk);
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL single_n1 got=%b exp=0", cmd_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (cmd_valid !== 1'b1) $display("FAIL single_n2 got=%b exp=1", cmd_valid); else n_pass++;
    consume();
    n_total++;
    if ({cmd_opcode, cmd_v0, cmd_v1, cmd_v2, cmd_colour} !== {8'h01, 32'h0020_0010, 32'h0040_0030, 32'h0010_0050, 32'h00FF_00FF})
      $display("FAIL single_cmd got=%h exp=%h", {cmd_opcode, cmd_v0, cmd_v1, cmd_v2, cmd_colour},
               {8'h01, 32'h0020_0010, 32'h0040_0030, 32'h0010_0050, 32'h00FF_00FF});
    else n_pass++;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || {cmd_opcode, cmd_v0, cmd_v1, cmd_v2, cmd_colour} !== {cur.op, cur.v0, cur.v1, cur.v2, cur.col})
        stable = 1'b0;
    end
    n_total++; if (stable !== 1'b1) $display("FAIL single_hold got=%b exp=1", stable); else n_pass++;
    do_ready();
    @(negedge clk);
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL single_drop got=%b exp=0", cmd_valid); else n_pass++;
    repeat (2) @(negedge clk);
    do_done(1'b0);
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status()) $display("FAIL single_status got=%h exp=%h", d, exp_status()); else n_pass++;
  endtask

  task automatic test_snapshot();
    logic [31:0] old_v0; int st; bit ok;
    old_v0 = m_reg[0];
    avs_wr(3'd5, 32'h0000_0001, st);
    avs_wr(3'd0, 32'h1234_5678, st);
    wait_valid(ok);
    n_total++; if (!ok) $display("FAIL snap_timeout got=0 exp=1"); else n_pass++;
    consume();
    n_total++; if (cmd_v0 !== old_v0) $display("FAIL snap_v0 got=%h exp=%h", cmd_v0, old_v0); else n_pass++;
    do_ready();
    do_done(1'b0);
  endtask

  task automatic test_fifo_full();
    logic [31:0] d; logic v1, v2; int st, st6; bit ok;
    for (int i = 0; i < 5; i++) begin
      avs_wr(3'd0, $urandom, st);
      avs_wr(3'd5, {24'd0, 8'($urandom_range(1, 255))}, st);
    end
    @(negedge clk);
    n_total++; if (cmd_valid !== 1'b1) $display("FAIL full_first got=%b exp=1", cmd_valid); else n_pass++;
    consume();
    n_total++; if ({cmd_opcode, cmd_v0} !== {cur.op, cur.v0}) $display("FAIL full_first_cmd got=%h exp=%h", {cmd_opcode, cmd_v0}, {cur.op, cur.v0}); else n_pass++;
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status()) $display("FAIL full_status got=%h exp=%h", d, exp_status()); else n_pass++;
    fork
      avs_wr(3'd5, {24'd0, 8'($urandom_range(1, 255))}, st6);
      begin
        repeat (4) @(negedge clk);
        do_ready();
        do_done(1'b0);
      end
    join
    n_total++; if (!(st6 > 0 && st6 < 100)) $display("FAIL full_stall got=%0d exp=1..99", st6); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      wait_valid(ok);
      n_total++; if (!ok) $display("FAIL drain_timeout got=0 exp=1 idx=%0d", i); else n_pass++;
      consume();
      n_total++;
      if ({cmd_opcode, cmd_v0, cmd_v1, cmd_v2, cmd_colour} !== {cur.op, cur.v0, cur.v1, cur.v2, cur.col})
        $display("FAIL drain_cmd%0d got=%h exp=%h", i, {cmd_opcode, cmd_v0}, {cur.op, cur.v0});
      else n_pass++;
      do_ready();
      do_done(1'b0);
    end
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status()) $display("FAIL drain_status got=%h exp=%h", d, exp_status()); else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic v1, v2; int st; bit quiet;
    avs_wr(3'd5, 32'h0000_0000, st);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) quiet = 1'b0;
    end
    n_total++; if (quiet !== 1'b1) $display("FAIL nop_issue got=%b exp=1", quiet); else n_pass++;
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status()) $display("FAIL nop_status got=%h exp=%h", d, exp_status()); else n_pass++;
    avs_rd(3'd5, d, v1, v2);
    n_total++; if (d !== {24'd0, m_last}) $display("FAIL nop_last got=%h exp=%h", d, {24'd0, m_last}); else n_pass++;
    avs_wr(3'd7, $urandom, st);
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status() || d[3] !== 1'b1) $display("FAIL err_set got=%h exp=%h", d, exp_status()); else n_pass++;
    avs_wr(3'd4, 32'h0000_0008, st);
    avs_rd(3'd6, d, v1, v2);
    n_total++; if (d !== 32'd0) $display("FAIL rsv_read got=%h exp=0", d); else n_pass++;
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status() || d[3] !== 1'b1) $display("FAIL rsv_err got=%h exp=%h", d, exp_status()); else n_pass++;
    avs_wr(3'd4, 32'h0000_0008, st);
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status() || d[3] !== 1'b0) $display("FAIL err_clr got=%h exp=%h", d, exp_status()); else n_pass++;
    avs_wr(3'd4, 32'h0000_0200, st);
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== 32'h0000_0004) $display("FAIL done_clr got=%h exp=00000004", d); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d; logic v1, v2; int st, mode, k; bit ok;
    for (int it = 0; it < 12; it++) begin
      for (int r = 0; r < 4; r++) avs_wr(3'(r), $urandom, st);
      avs_wr(3'd5, {24'd0, 8'($urandom_range(1, 255))}, st);
      wait_valid(ok);
      n_total++; if (!ok) $display("FAIL rnd_timeout got=0 exp=1 it=%0d", it); else n_pass++;
      consume();
      n_total++;
      if ({cmd_opcode, cmd_v0, cmd_v1, cmd_v2, cmd_colour} !== {cur.op, cur.v0, cur.v1, cur.v2, cur.col})
        $display("FAIL rnd_cmd it=%0d got=%h exp=%h", it, {cmd_opcode, cmd_v0, cmd_v1, cmd_v2, cmd_colour}, {cur.op, cur.v0, cur.v1, cur.v2, cur.col});
      else n_pass++;
      mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (mode == 1) do_done(1'b0);
      if (mode == 2) do_done(1'b1);
      else do_ready();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_done(1'b0);
      avs_rd(3'd4, d, v1, v2);
      n_total++; if (d !== exp_status()) $display("FAIL rnd_status it=%0d mode=%0d got=%h exp=%h", it, mode, d, exp_status()); else n_pass++;
      k = $urandom_range(0, 3);
      avs_rd(3'(k), d, v1, v2);
      n_total++; if (d !== m_reg[k]) $display("FAIL rnd_reg%0d got=%h exp=%h", k, d, m_reg[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v1, v2; int st; bit ok, quiet;
    for (int i = 0; i < 3; i++) avs_wr(3'd5, {24'd0, 8'($urandom_range(1, 255))}, st);
    wait_valid(ok);
    n_total++; if (!ok) $display("FAIL mid_timeout got=0 exp=1"); else n_pass++;
    consume();
    do_ready();
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== exp_status()) $display("FAIL mid_pre got=%h exp=%h", d, exp_status()); else n_pass++;
    apply_reset();
    n_total++; if (cmd_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", cmd_valid); else n_pass++;
    do_done(1'b0);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) quiet = 1'b0;
    end
    n_total++; if (quiet !== 1'b1) $display("FAIL mid_quiet got=%b exp=1", quiet); else n_pass++;
    avs_rd(3'd4, d, v1, v2);
    n_total++; if (d !== 32'h0000_0004) $display("FAIL mid_status got=%h exp=00000004", d); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    avs_chipselect = 1'b0; avs_address = 3'd0; avs_write = 1'b0;
    avs_writedata = 32'd0; avs_read = 1'b0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    model_reset();
    test_reset();
    test_readback();
    test_single_cmd();
    test_snapshot();
    test_fifo_full();
    test_errors();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
